// File: rtl/gpio_pkg.sv
// Shared encodings for the GPIO pad bank: drive modes, per-channel FSM states
// and counter widths.
package gpio_pkg;

  localparam logic [1:0] MODE_PUSHPULL  = 2'd0;
  localparam logic [1:0] MODE_OPENDRAIN = 2'd1;
  localparam logic [1:0] MODE_INPUT     = 2'd2;
  localparam logic [1:0] MODE_RESERVED  = 2'd3;

  localparam logic [1:0] ST_HIZ      = 2'd0;
  localparam logic [1:0] ST_WAIT_DRV = 2'd1;
  localparam logic [1:0] ST_DRIVE    = 2'd2;
  localparam logic [1:0] ST_SETTLE   = 2'd3;

  localparam int TA_CNT_W  = 4;
  localparam int DEB_CNT_W = 8;

  // The reserved encoding behaves exactly like INPUT.
  function automatic logic isInputMode(input logic [1:0] mode);
    return (mode == MODE_INPUT) || (mode == MODE_RESERVED);
  endfunction

endpackage

// File: rtl/tristate_pad_channel.sv
// One GPIO pad channel: turnaround FSM, registered drive value, input
// synchroniser, debounce filter and readback masking.
module tristate_pad_channel
  import gpio_pkg::*;
#(
  parameter int TURNAROUND  = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 0
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic [1:0] mode,
  input  logic       outputEnable,
  input  logic       xOut,
  input  logic       padIn,
  output logic       padOe,
  output logic       padOut,
  output logic       xIn,
  output logic       driving,
  output logic       busy
);

  localparam logic [TA_CNT_W-1:0] TA_LOAD = TA_CNT_W'(TURNAROUND);
  localparam logic [TA_CNT_W-1:0] TA_ONE  = TA_CNT_W'(1);

  logic [1:0]             state;
  logic [1:0]             stateNext;
  logic [TA_CNT_W-1:0]    taCnt;
  logic [TA_CNT_W-1:0]    taCntNext;
  logic                   driveQ;
  logic [SYNC_STAGES-1:0] syncQ;
  logic                   synced;
  logic                   candidate;
  logic                   masked;
  logic                   wantDrive;

  assign wantDrive = outputEnable && !isInputMode(mode);
  assign synced    = syncQ[SYNC_STAGES-1];

  always_comb begin
    stateNext = state;
    taCntNext = taCnt;
    case (state)
      ST_HIZ: begin
        if (wantDrive) begin
          if (TURNAROUND == 0) begin
            stateNext = ST_DRIVE;
          end else begin
            stateNext = ST_WAIT_DRV;
            taCntNext = TA_LOAD;
          end
        end
      end
      ST_WAIT_DRV: begin
        if (!wantDrive) begin
          stateNext = ST_HIZ;
          taCntNext = '0;
        end else if (taCnt == TA_ONE) begin
          stateNext = ST_DRIVE;
          taCntNext = '0;
        end else begin
          taCntNext = taCnt - TA_ONE;
        end
      end
      ST_DRIVE: begin
        if (!wantDrive) begin
          if (TURNAROUND == 0) begin
            stateNext = ST_HIZ;
          end else begin
            stateNext = ST_SETTLE;
            taCntNext = TA_LOAD;
          end
        end
      end
      ST_SETTLE: begin
        // Settle always runs to completion; OE is only looked at on the way out.
        if (taCnt == TA_ONE) begin
          if (wantDrive) begin
            stateNext = ST_WAIT_DRV;
            taCntNext = TA_LOAD;
          end else begin
            stateNext = ST_HIZ;
            taCntNext = '0;
          end
        end else begin
          taCntNext = taCnt - TA_ONE;
        end
      end
      default: begin
        stateNext = ST_HIZ;
        taCntNext = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state  <= ST_HIZ;
      taCnt  <= '0;
      driveQ <= 1'b0;
      syncQ  <= '0;
    end else begin
      state  <= stateNext;
      taCnt  <= taCntNext;
      driveQ <= xOut;
      syncQ  <= {syncQ[SYNC_STAGES-2:0], padIn};
    end
  end

  // Mode is applied combinationally so a mode change in DRIVE hits the pad at once.
  always_comb begin
    padOe  = 1'b0;
    padOut = driveQ;
    if (state == ST_DRIVE) begin
      case (mode)
        MODE_PUSHPULL: padOe = 1'b1;
        MODE_OPENDRAIN: begin
          padOe  = !driveQ;
          padOut = 1'b0;
        end
        default: padOe = 1'b0;
      endcase
    end
  end

  if (DEBOUNCE == 0) begin : g_noDebounce
    assign candidate = synced;
  end else begin : g_debounce
    localparam logic [DEB_CNT_W-1:0] DEB_LEN = DEB_CNT_W'(DEBOUNCE);
    localparam logic [DEB_CNT_W-1:0] DEB_ONE = DEB_CNT_W'(1);

    logic                 lastSynced;
    logic                 candQ;
    logic [DEB_CNT_W-1:0] runCnt;
    logic [DEB_CNT_W-1:0] runNext;

    // runCnt is the length of the current run of identical samples, saturating at DEB_LEN.
    always_comb begin
      runNext = DEB_ONE;
      if ((runCnt != '0) && (synced == lastSynced)) begin
        runNext = (runCnt == DEB_LEN) ? runCnt : runCnt + DEB_ONE;
      end
    end

    always_ff @(posedge clk) begin
      if (!rstN) begin
        lastSynced <= 1'b0;
        runCnt     <= '0;
        candQ      <= 1'b0;
      end else begin
        lastSynced <= synced;
        runCnt     <= runNext;
        if (runNext == DEB_LEN) candQ <= synced;
      end
    end

    assign candidate = candQ;
  end

  // Push-pull hides its own drive; open-drain keeps readback for wired-AND detection.
  always_comb begin
    case (mode)
      MODE_PUSHPULL:  masked = (state != ST_HIZ);
      MODE_OPENDRAIN: masked = (state == ST_SETTLE);
      default:        masked = 1'b0;
    endcase
  end

  assign xIn     = candidate && !masked;
  assign driving = (state == ST_DRIVE);
  assign busy    = (state == ST_WAIT_DRV) || (state == ST_SETTLE);

endmodule

// File: rtl/tristate_pad_bank.sv
// Bank of N_CH bidirectional GPIO pads; one independent channel per pin, with
// the tri-state buffer resolved here at the pin.
module tristate_pad_bank
  import gpio_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int TURNAROUND  = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [2*N_CH-1:0] i_mode,
  input  logic [N_CH-1:0]   i_outputEnable,
  input  logic [N_CH-1:0]   i_xOut,
  output logic [N_CH-1:0]   o_xIn,
  output logic [N_CH-1:0]   o_driving,
  output logic [N_CH-1:0]   o_busy,
  inout  wire  [N_CH-1:0]   b_xIO
);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic padOe;
    logic padOut;

    tristate_pad_channel #(
      .TURNAROUND (TURNAROUND),
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE   (DEBOUNCE)
    ) u_channel (
      .clk         (i_clk),
      .rstN        (i_rst_n),
      .mode        (i_mode[2*c +: 2]),
      .outputEnable(i_outputEnable[c]),
      .xOut        (i_xOut[c]),
      .padIn       (b_xIO[c]),
      .padOe       (padOe),
      .padOut      (padOut),
      .xIn         (o_xIn[c]),
      .driving     (o_driving[c]),
      .busy        (o_busy[c])
    );

    assign b_xIO[c] = padOe ? padOut : 1'bz;
  end

endmodule

// File: tb/tb_tristate_pad_bank.sv
// Self-checking bench for tristate_pad_bank: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_tristate_pad_bank;

  localparam int N_CH = 4;
  localparam int TA   = 2;
  localparam int SS   = 2;
  localparam int DB   = 3;
  localparam logic [1:0] PP = 2'd0;
  localparam logic [1:0] OD = 2'd1;
  localparam logic [1:0] IN = 2'd2;

  logic              clk = 1'b0;
  logic              rstN;
  logic [2*N_CH-1:0] mode;
  logic [N_CH-1:0]   oe;
  logic [N_CH-1:0]   xOut;
  logic [N_CH-1:0]   extVal;
  logic [N_CH-1:0]   xIn;
  logic [N_CH-1:0]   driving;
  logic [N_CH-1:0]   busy;
  logic [N_CH-1:0]   extDrv;
  wire  [N_CH-1:0]   pad;

  int vecs = 0;
  int miscmp = 0;

  always #5 clk = ~clk;

  tristate_pad_bank #(
    .N_CH(N_CH), .TURNAROUND(TA), .SYNC_STAGES(SS), .DEBOUNCE(DB)
  ) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_mode(mode), .i_outputEnable(oe),
    .i_xOut(xOut), .o_xIn(xIn), .o_driving(driving), .o_busy(busy), .b_xIO(pad)
  );

  // External world: drives extVal onto each pad whenever the model says the DUT has released it.
  for (genvar i = 0; i < N_CH; i++) begin : g_ext
    assign pad[i] = extDrv[i] ? extVal[i] : 1'bz;
  end

  // ---------------- behavioural model ----------------
  // ph: 0 idle, 1 pre-drive dead time, 2 driving, 3 post-drive dead time
  int            ph[N_CH];
  int            left[N_CH];
  logic [N_CH-1:0] mDq = '0;
  logic [N_CH-1:0] cand = '0;
  bit            syncH[N_CH][$];
  bit            debH[N_CH][$];
  bit            mVld = 1'b0;
  logic [N_CH-1:0] mOn, mVal, padExp;

  always_comb begin
    mOn = '0;
    mVal = '0;
    padExp = '0;
    for (int c = 0; c < N_CH; c++) begin
      mOn[c] = (ph[c] == 2) &&
               ((mode[2*c +: 2] == PP) || ((mode[2*c +: 2] == OD) && !mDq[c]));
      mVal[c] = (mode[2*c +: 2] == PP) ? mDq[c] : 1'b0;
      padExp[c] = mOn[c] ? mVal[c] : extVal[c];
    end
  end
  assign extDrv = ~mOn;

  always @(posedge clk) begin
    logic [N_CH-1:0] padNow;
    bit want, s, allEq;
    int nph;
    padNow = padExp;
    mVld <= 1'b1;
    for (int c = 0; c < N_CH; c++) begin
      if (!rstN) begin
        ph[c]  <= 0;
        mDq[c] <= 1'b0;
        left[c] = 0;
        cand[c] = 1'b0;
        syncH[c].delete();
        for (int k = 0; k < SS; k++) syncH[c].push_back(1'b0);
        debH[c].delete();
      end else begin
        want = oe[c] && !mode[2*c+1];
        nph = ph[c];
        case (ph[c])
          0: if (want) begin nph = 1; left[c] = TA; end
          1: if (!want) nph = 0;
             else begin left[c]--; if (left[c] == 0) nph = 2; end
          2: if (!want) begin nph = 3; left[c] = TA; end
          default: begin
            left[c]--;
            if (left[c] == 0) begin
              if (want) begin nph = 1; left[c] = TA; end
              else nph = 0;
            end
          end
        endcase
        ph[c]  <= nph;
        mDq[c] <= xOut[c];
        s = syncH[c].pop_front();
        syncH[c].push_back(padNow[c]);
        debH[c].push_back(s);
        if (debH[c].size() > DB) void'(debH[c].pop_front());
        if (debH[c].size() == DB) begin
          allEq = 1'b1;
          foreach (debH[c][k]) if (debH[c][k] != s) allEq = 1'b0;
          if (allEq) cand[c] = s;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [N_CH-1:0] eX, eD, eB;
    bit mask;
    if (mVld) begin
      for (int c = 0; c < N_CH; c++) begin
        mask = ((mode[2*c +: 2] == PP) && (ph[c] != 0)) ||
               ((mode[2*c +: 2] == OD) && (ph[c] == 3));
        eX[c] = cand[c] && !mask;
        eD[c] = (ph[c] == 2);
        eB[c] = (ph[c] == 1) || (ph[c] == 3);
      end
      chk("model_xIn", 32'(xIn), 32'(eX));
      chk("model_driving", 32'(driving), 32'(eD));
      chk("model_busy", 32'(busy), 32'(eB));
      chk("model_pad", 32'(pad), 32'(padExp));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstN = 1'b0; oe = '1; xOut = '1; mode = '0; extVal = '0;
    step(3);
    chk("rst_driving", 32'(driving), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_xIn", 32'(xIn), 32'(0));
    chk("rst_pad", 32'(pad), 32'(0));

    rstN = 1'b1; oe = '0; xOut = '0; extVal = '1;
    mode = {IN, IN, OD, PP};
    step(8);
    chk("idle_xIn", 32'(xIn), 32'hF);

    // push-pull on ch0
    xOut[0] = 1'b1; oe[0] = 1'b1;
    step(1);
    chk("pp_busy_n", 32'(busy[0]), 32'(1));
    chk("pp_drv_n", 32'(driving[0]), 32'(0));
    chk("pp_mask_n", 32'(xIn[0]), 32'(0));
    step(1);
    chk("pp_busy_n1", 32'(busy[0]), 32'(1));
    step(1);
    chk("pp_drv_n2", 32'(driving[0]), 32'(1));
    chk("pp_busy_n2", 32'(busy[0]), 32'(0));
    chk("pp_pad1", 32'(pad[0]), 32'(1));
    xOut[0] = 1'b0;
    step(1);
    chk("pp_pad0", 32'(pad[0]), 32'(0));
    oe[0] = 1'b0;
    step(1);
    chk("pp_rel_drv", 32'(driving[0]), 32'(0));
    chk("pp_rel_busy", 32'(busy[0]), 32'(1));
    chk("pp_rel_pad", 32'(pad[0]), 32'(1));
    chk("pp_settle_mask", 32'(xIn[0]), 32'(0));
    step(1);
    chk("pp_settle2", 32'(busy[0]), 32'(1));
    step(1);
    chk("pp_idle_busy", 32'(busy[0]), 32'(0));
    chk("pp_unmask", 32'(xIn[0]), 32'(1));

    // open-drain on ch1
    xOut[1] = 1'b0; oe[1] = 1'b1;
    step(3);
    chk("od_drv", 32'(driving[1]), 32'(1));
    chk("od_pad0", 32'(pad[1]), 32'(0));
    xOut[1] = 1'b1;
    step(1);
    chk("od_pad_rel", 32'(pad[1]), 32'(1));
    step(6);
    chk("od_readback1", 32'(xIn[1]), 32'(1));
    extVal[1] = 1'b0;
    step(4);
    chk("od_hold_early", 32'(xIn[1]), 32'(1));
    step(1);
    chk("od_hold_seen", 32'(xIn[1]), 32'(0));
    oe[1] = 1'b0; extVal[1] = 1'b1;
    step(6);

    // input-only ch2 with OE asserted
    oe[2] = 1'b1;
    step(2);
    chk("in_drv", 32'(driving[2]), 32'(0));
    chk("in_busy", 32'(busy[2]), 32'(0));
    extVal[2] = 1'b0;
    step(2);
    extVal[2] = 1'b1;
    step(6);
    chk("in_glitch", 32'(xIn[2]), 32'(1));
    extVal[2] = 1'b0;
    step(3);
    extVal[2] = 1'b1;
    step(2);
    chk("in_stable_low", 32'(xIn[2]), 32'(0));
    step(3);
    chk("in_stable_high", 32'(xIn[2]), 32'(1));
    oe[2] = 1'b0;

    // abort from idle on ch3
    mode[7:6] = PP; oe[3] = 1'b1;
    step(1);
    chk("abort_busy", 32'(busy[3]), 32'(1));
    oe[3] = 1'b0;
    step(1);
    chk("abort_idle", 32'(busy[3]), 32'(0));
    chk("abort_nodrv", 32'(driving[3]), 32'(0));

    // OE re-asserted during settle on ch0
    oe[0] = 1'b1;
    step(3);
    chk("resettle_drv", 32'(driving[0]), 32'(1));
    oe[0] = 1'b0;
    step(1);
    oe[0] = 1'b1;
    step(2);
    chk("resettle_busy", 32'(busy[0]), 32'(1));
    chk("resettle_nodrv", 32'(driving[0]), 32'(0));
    step(2);
    chk("resettle_redrv", 32'(driving[0]), 32'(1));

    // reset while driving
    extVal[0] = 1'b0; xOut[0] = 1'b1;
    step(1);
    chk("pre_rst_pad", 32'(pad[0]), 32'(1));
    rstN = 1'b0;
    step(1);
    chk("mid_rst_pad", 32'(pad[0]), 32'(0));
    chk("mid_rst_drv", 32'(driving), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_xIn", 32'(xIn), 32'(0));
    rstN = 1'b1;
    step(4);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(15) == 0) mode[2*c +: 2] = 2'($urandom_range(3));
        if ($urandom_range(3) == 0) oe[c] = ~oe[c];
        if ($urandom_range(3) == 0) extVal[c] = ~extVal[c];
      end
      xOut = N_CH'($urandom);
      rstN = ($urandom_range(299) != 0);
      step(1);
    end
    rstN = 1'b1;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
